key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of independent push-button channels.
REQ-002 SHALL have parameter CNT_MAX, default 1000000, giving the debounce stability period in clk_clk cycles (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 SHALL have port clk_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port key_n_in, input, WIDTH, raw active-low board push buttons, asynchronous to clk_clk.
REQ-006 SHALL have port btn_level, output, WIDTH, debounced active-high button state, which drives buttons_0_external_connection_export of soc_system.
REQ-007 SHALL have port btn_press, output, WIDTH, one-cycle pulse per channel on each debounced press.
REQ-008 SHALL have port btn_release, output, WIDTH, one-cycle pulse per channel on each debounced release.
REQ-009 SHALL have port btn_any, output, 1, the OR of all btn_level bits.

Function
REQ-010 SHALL pass each key_n_in bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL hold, per channel, a registered stable state stable_n (active-low) and a counter of width ceil(log2(CNT_MAX)).
REQ-012 SHALL clear a channel's counter to 0 on any edge where sync2 equals stable_n.
REQ-013 SHALL increment the counter by 1 on an edge where sync2 differs from stable_n and the counter is below CNT_MAX-1.
REQ-014 SHALL load stable_n with sync2 and clear the counter to 0 on an edge where sync2 differs from stable_n and the counter equals CNT_MAX-1.
REQ-015 SHALL drive btn_level as the registered inverse of stable_n.
REQ-016 SHALL produce the following latency: if key_n_in changes cleanly and is first sampled by sync1 at edge k, btn_level SHALL change on edge k+CNT_MAX+1 and not before.
REQ-017 SHALL ensure that a disturbance shorter than CNT_MAX cycles at sync2 (a glitch) returns the counter to 0 and causes no change on any output.
REQ-018 SHALL register btn_press[i]=1 for exactly one cycle on the same edge at which btn_level[i] goes 0->1, and 0 otherwise.
REQ-019 SHALL register btn_release[i]=1 for exactly one cycle on the same edge at which btn_level[i] goes 1->0, and 0 otherwise.
REQ-020 SHALL never assert btn_press[i] and btn_release[i] in the same cycle.
REQ-021 SHALL keep channels fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 SHALL derive btn_any combinationally from the btn_level registers, so it has no extra latency.
REQ-023 SHALL never let the counter wrap; CNT_MAX-1 is its maximum value.

Reset
REQ-024 SHALL, while reset_reset=1 and regardless of clk_clk, set sync1, sync2 and stable_n to all-ones (released), all counters to 0, and btn_level, btn_press, btn_release and btn_any to 0.
REQ-025 SHALL, on reset assertion mid-count, discard the partial count; a button held through reset SHALL need the full REQ-016 latency, counted from the first post-reset sampling edge, before btn_press fires.
REQ-026 SHALL, on reset of a debounced-pressed channel, drop btn_level with no btn_release pulse.

Verification (CNT_MAX=8, WIDTH=4)
REQ-027 SHALL cover a clean press: key_n_in[0] 1->0 first sampled at edge k -> btn_level[0]=1 and btn_press[0]=1 for one cycle at edge k+9, btn_any=1, all other bits 0.
REQ-028 SHALL cover a glitch: key_n_in[1] low for 5 cycles then high -> btn_level, btn_press and btn_release all remain 0 and the counter returns to 0.
REQ-029 SHALL cover a release: debounced-pressed channel 0, key_n_in[0] 0->1 at edge k -> btn_release[0] one-cycle pulse and btn_level[0]=0 at edge k+9.
REQ-030 SHALL cover simultaneous presses: key_n_in 4'b1111->4'b0101 at one edge -> btn_press=4'b1010 in a single cycle, 9 edges later.
REQ-031 SHALL cover reset mid-count: reset_reset pulsed after 5 counted cycles with the key held low -> outputs 0 immediately; after deassertion btn_press fires exactly 9 edges after the first post-reset sampling edge.
REQ-032 SHALL cover a chatter burst: 3 toggles spaced 3 cycles apart followed by a steady low -> exactly one btn_press, 9 edges after the last toggle's sampling edge.

Source files
------------

// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel
// stability counter, debounced level plus one-cycle press/release pulses.
module key_debouncer #(
    parameter int WIDTH   = 4,
    parameter int CNT_MAX = 1000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] key_n_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             btn_any
);

    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_n_r;
    logic [WIDTH-1:0] stable_n_nxt_s;
    logic [WIDTH-1:0] load_s;
    logic [CW-1:0]    cnt_r     [WIDTH];
    logic [CW-1:0]    cnt_nxt_s [WIDTH];

    // Per-channel counter update and stable-state load decision
    always_comb begin
        load_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = '0;
            if (sync2_r[i] != stable_n_r[i]) begin
                if (cnt_r[i] == CNT_TOP) begin
                    load_s[i]    = 1'b1;
                    cnt_nxt_s[i] = '0;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = '0;
            end
        end
        // A load always flips the stable state, since it only happens when sync2 differs
        stable_n_nxt_s = stable_n_r ^ load_s;
    end

    // Two-flop synchronizer for the asynchronous board keys
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= key_n_in;
            sync2_r <= sync1_r;
        end
    end

    // Stability counters
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Level is registered together with stable_n so it changes on the load edge itself
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stable_n_r  <= '1;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            stable_n_r  <= stable_n_nxt_s;
            btn_level   <= ~stable_n_nxt_s;
            btn_press   <= load_s & ~sync2_r;
            btn_release <= load_s & sync2_r;
        end
    end

    assign btn_any = |btn_level;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer (WIDTH=4, CNT_MAX=8): stimulus pushes
// expected pulse events, a negedge monitor pops and compares them.
module tb_key_debouncer;

    localparam int LAT = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'b1111;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       btn_any;

    typedef struct {
        int         edge_no;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } ev_t;

    ev_t q[$];
    int  edge_cnt = 0;
    int  checks   = 0;
    int  failures = 0;

    key_debouncer #(.WIDTH(4), .CNT_MAX(8)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .key_n_in    (key_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_any     (btn_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the next expected event
    always @(negedge clk) begin
        ev_t e;
        if (!rst && ((btn_press | btn_release) != 4'b0000)) begin
            if (q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse press=%b release=%b edge=%0d", btn_press, btn_release, edge_cnt);
            end else begin
                e = q.pop_front();
                check("event_edge", edge_cnt, e.edge_no);
                check("event_press", int'(btn_press), int'(e.press));
                check("event_release", int'(btn_release), int'(e.rel));
                check("event_level", int'(btn_level), int'(e.level));
                check("event_any", int'(btn_any), int'(e.level != 4'b0000));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive keys just after a negedge; the next posedge is the sampling edge
    task automatic drive(input logic [3:0] v, output int k);
        @(negedge clk);
        key_n = v;
        k = edge_cnt + 1;
    endtask

    task automatic expect_ev(input int edge_no, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.edge_no = edge_no;
        e.press   = p;
        e.rel     = r;
        e.level   = l;
        q.push_back(e);
    endtask

    initial begin
        int k;
        // Reset state, checked while held in reset with the clock running
        cycles(3);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(btn_press), 0);
        check("rst_release", int'(btn_release), 0);
        check("rst_any", int'(btn_any), 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(4);

        // Clean press on channel 0
        drive(4'b1110, k);
        expect_ev(k + LAT, 4'b0001, 4'b0000, 4'b0001);
        cycles(LAT - 2);
        check("press_not_early", int'(btn_level), 0);
        cycles(8);
        check("press_level", int'(btn_level), 1);
        check("press_any", int'(btn_any), 1);

        // Glitch on channel 1: low for 5 cycles only
        drive(4'b1100, k);
        cycles(4);
        drive(4'b1110, k);
        cycles(15);
        check("glitch_level", int'(btn_level), 1);

        // Release channel 0
        drive(4'b1111, k);
        expect_ev(k + LAT, 4'b0000, 4'b0001, 4'b0000);
        cycles(15);
        check("release_level", int'(btn_level), 0);

        // Simultaneous presses on channels 1 and 3, then simultaneous release
        drive(4'b0101, k);
        expect_ev(k + LAT, 4'b1010, 4'b0000, 4'b1010);
        cycles(15);
        drive(4'b1111, k);
        expect_ev(k + LAT, 4'b0000, 4'b1010, 4'b0000);
        cycles(15);

        // Channel 2 debounced pressed, then channel 0 counting when reset hits
        drive(4'b1011, k);
        expect_ev(k + LAT, 4'b0100, 4'b0000, 4'b0100);
        cycles(15);
        drive(4'b1010, k);
        cycles(6);
        #1 rst = 1'b1;
        #1;
        check("midrst_level", int'(btn_level), 0);
        check("midrst_any", int'(btn_any), 0);
        check("midrst_release", int'(btn_release), 0);
        cycles(3);
        rst = 1'b0;
        k = edge_cnt + 1;
        expect_ev(k + LAT, 4'b0101, 4'b0000, 4'b0101);
        cycles(15);
        drive(4'b1111, k);
        expect_ev(k + LAT, 4'b0000, 4'b0101, 4'b0000);
        cycles(15);

        // Chatter on channel 3: three toggles 3 cycles apart, then steady low
        drive(4'b0111, k);
        cycles(2);
        drive(4'b1111, k);
        cycles(2);
        drive(4'b0111, k);
        expect_ev(k + LAT, 4'b1000, 4'b0000, 4'b1000);
        cycles(20);
        check("chatter_level", int'(btn_level), 8);

        check("events_pending", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
